instruction_controller: RTL and testbench
=========================================

# instruction_controller

Instruction register, decoder and control state machine that drives the control inputs of the register/ALU datapath. It accepts one 16-bit instruction, decodes the MOV, ADD, CMP, AND and MVN formats, and sequences the datapath's register-file, A/B/C/status load and mux-select signals over multiple cycles. It raises `w` when idle. The block sits between the instruction source/testbench and the datapath, and is the issuing side of the datapath's control interface.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in` input 16: instruction word.
- `load` input 1: latch `in` into the IR; honoured only in WAIT.
- `s` input 1: start execution of the IR contents; honoured only in WAIT.
- `w` output 1: 1 while in WAIT (idle, ready).
- `sximm8`, `sximm5` output 16: `{{8{ir[7]}},ir[7:0]}` and `{{11{ir[4]}},ir[4:0]}`.
- `shift` output 2: `ir[4:3]` for register-operand instructions, otherwise 00.
- `ALUop` output 2: `ir[12:11]`.
- `readnum`, `writenum` output 3: both equal the register selected by the current state (Rn=`ir[10:8]`, Rd=`ir[7:5]`, Rm=`ir[2:0]`).
- `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `write` output 1: datapath controls.
- `vsel` output 4: one-hot write-back select. 0001 selects mdata, 0010 sximm8, 0100 PC, 1000 C.

## Operation
- Instruction fields: opcode=`ir[15:13]`, op=`ir[12:11]`. The block supports 110/10 MOV Rn,#im8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN.
- IR: 16-bit register, updated with `in` when `load`=1 and state=WAIT. It holds its value otherwise.
- Moore FSM. Control outputs are functions of the state and IR only. Any control not listed for a state is 0, and `vsel`=0000.
  - WAIT: `w`=1. If `s`=1, next state is DECODE.
  - DECODE: no controls asserted. Next state depends on the instruction:
    - MOV imm goes to WR_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Any other opcode/op goes to WAIT, with nothing written.
  - WR_IMM: register select=Rn, `vsel`=0010, `write`=1. Next state is WAIT.
  - GET_A: register select=Rn, `loada`=1. Next state is GET_B.
  - GET_B: register select=Rm, `loadb`=1, `shift`=sh. Next state is EXEC.
  - EXEC: `shift`=sh and `bsel`=0.
    - `asel`=1 for MOV reg (A forced to 0, ALUop 00 adds), otherwise 0.
    - CMP: `loads`=1, `loadc`=0, next state WAIT.
    - All other instructions: `loadc`=1, next state WR_REG.
  - WR_REG: register select=Rd, `vsel`=1000, `write`=1, `shift`=sh. Next state is WAIT.
- `loads` is asserted only in EXEC for CMP. `bsel` is never 1 in this instruction set; `sximm5` is still driven.
- `s` held high through WAIT re-launches the same IR immediately after completion.
- `load` and `s` outside WAIT are ignored.

## Timing
- Reset: on a rising edge with `rst_n`=0, state becomes WAIT and IR becomes 0000.
- While `rst_n`=0, all control outputs are forced to 0 combinationally, including `write`; `w` reads 1.
- Reset mid-instruction aborts the instruction. No further register-file write occurs, and the FSM resumes in WAIT.
- `load` and `s` asserted in the same WAIT cycle: the IR captures `in` on that edge and DECODE uses the new value.
- Cycles from the `s` edge until WAIT is re-entered (`w`=1):

| Instruction | Path | Cycles |
|---|---|---|
| MOV imm | DECODE, WR_IMM | 2 |
| MOV reg / MVN | DECODE, GET_B, EXEC, WR_REG | 4 |
| ADD / AND | DECODE, GET_A, GET_B, EXEC, WR_REG | 5 |
| CMP | DECODE, GET_A, GET_B, EXEC | 4 |
| undefined | DECODE | 1 |

- Every control output is stable for the whole cycle of its state. The datapath samples them on the next rising edge.

## Test plan
- Reset with `rst_n`=0 for 2 cycles: `w`=1, every control output is 0, IR=0000. Pulsing `s` during reset has no effect.
- `in`=D0FB (MOV R0,#-5), `load`=1, then `s`=1:
  - WR_IMM cycle: `sximm8`=FFFB, `writenum`=0, `vsel`=0010, `write`=1.
  - `w` returns to 1 after 2 cycles.
- `in`=A148 (ADD R2,R1,R0,LSL#1):
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1, `shift`=01.
  - EXEC: `loadc`=1, `ALUop`=00.
  - WR_REG: `writenum`=2, `vsel`=1000.
  - Total 5 cycles.
- `in`=A900 (CMP R1,R0):
  - EXEC has `loads`=1, `loadc`=0.
  - `write` is never 1.
  - WAIT is reached after 4 cycles.
- `in`=B867 (MVN R3,R7) skips GET_A: GET_B `readnum`=7, WR_REG `writenum`=3.
- `in`=C095 (MOV R4,R5,LSR): EXEC has `asel`=1 and `shift`=10, followed by WR_REG `writenum`=4.
- `in`=E000 (undefined) returns to WAIT after DECODE with no write.
- Deasserting `rst_n` during GET_B of the ADD gives WAIT on the next edge and `write` stays 0 throughout.

Source files
------------

// File: rtl/instruction_controller.sv
// Instruction register, decoder and Moore control FSM for the register/ALU datapath.
// Control outputs are registered per state and forced to their idle values while rst_n is low.
module instruction_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic        write,
   output logic [3:0]  vsel
);

   typedef enum logic [2:0] {
      WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG
   } state_t;

   typedef struct packed {
      logic       w;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic [3:0] vsel;
      logic [1:0] shift;
      logic [2:0] rsel;
   } ctrl_t;

   state_t      state, next_state;
   logic [15:0] ir, next_ir;
   ctrl_t       ctrl_q;

   function automatic state_t decode_next(input logic [15:0] i);
      case (i[15:11])
         5'b11010:                     return WR_IMM;
         5'b11000, 5'b10111:           return GET_B;
         5'b10100, 5'b10101, 5'b10110: return GET_A;
         default:                      return WAIT;
      endcase
   endfunction

   // Control word for a state; evaluated for the upcoming state so outputs come straight from flops.
   function automatic ctrl_t ctrl_of(input state_t st, input logic [15:0] i);
      ctrl_t c;
      c = '0;
      case (st)
         WAIT:    c.w = 1'b1;
         WR_IMM:  begin
            c.rsel  = i[10:8];
            c.vsel  = 4'b0010;
            c.write = 1'b1;
         end
         GET_A:   begin
            c.rsel  = i[10:8];
            c.loada = 1'b1;
         end
         GET_B:   begin
            c.rsel  = i[2:0];
            c.loadb = 1'b1;
            c.shift = i[4:3];
         end
         EXEC:    begin
            c.shift = i[4:3];
            c.asel  = (i[15:13] == 3'b110);
            c.loads = (i[15:11] == 5'b10101);
            c.loadc = (i[15:11] != 5'b10101);
         end
         WR_REG:  begin
            c.rsel  = i[7:5];
            c.vsel  = 4'b1000;
            c.write = 1'b1;
            c.shift = i[4:3];
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      next_state = state;
      next_ir    = ir;
      case (state)
         WAIT:    begin
            if (load) next_ir = in;
            if (s)    next_state = DECODE;
         end
         DECODE:  next_state = decode_next(ir);
         WR_IMM:  next_state = WAIT;
         GET_A:   next_state = GET_B;
         GET_B:   next_state = EXEC;
         EXEC:    next_state = (ir[15:11] == 5'b10101) ? WAIT : WR_REG;
         WR_REG:  next_state = WAIT;
         default: next_state = WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= WAIT;
         ir     <= 16'h0000;
         ctrl_q <= ctrl_of(WAIT, 16'h0000);
      end else begin
         state  <= next_state;
         ir     <= next_ir;
         ctrl_q <= ctrl_of(next_state, next_ir);
      end
   end

   // Reset overrides every output combinationally so no write can leak out mid-instruction.
   assign w        = rst_n ? ctrl_q.w     : 1'b1;
   assign loada    = rst_n & ctrl_q.loada;
   assign loadb    = rst_n & ctrl_q.loadb;
   assign loadc    = rst_n & ctrl_q.loadc;
   assign loads    = rst_n & ctrl_q.loads;
   assign asel     = rst_n & ctrl_q.asel;
   assign bsel     = rst_n & ctrl_q.bsel;
   assign write    = rst_n & ctrl_q.write;
   assign vsel     = rst_n ? ctrl_q.vsel  : 4'b0000;
   assign shift    = rst_n ? ctrl_q.shift : 2'b00;
   assign readnum  = rst_n ? ctrl_q.rsel  : 3'b000;
   assign writenum = rst_n ? ctrl_q.rsel  : 3'b000;
   assign ALUop    = rst_n ? ir[12:11]    : 2'b00;
   assign sximm8   = rst_n ? {{8{ir[7]}}, ir[7:0]}  : 16'h0000;
   assign sximm5   = rst_n ? {{11{ir[4]}}, ir[4:0]} : 16'h0000;

endmodule

// File: tb/tb_instruction_controller.sv
// Randomized scoreboard bench for instruction_controller: the driver queues the expected
// per-cycle outputs from an instruction-level model, a negedge monitor pops and compares.
module tb_instruction_controller;

   typedef struct packed {
      logic        w;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic        write;
      logic [3:0]  vsel;
      logic [1:0]  shift;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic [1:0]  alu_op;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        s = 1'b0;
   logic [15:0] in_word = 16'h0000;

   logic        w, loada, loadb, loadc, loads, asel, bsel, write;
   logic [15:0] sximm8, sximm5;
   logic [1:0]  shift, ALUop;
   logic [2:0]  readnum, writenum;
   logic [3:0]  vsel;

   obs_t        exp_q[$];
   string       tag_q[$];
   obs_t        seq_q[$];
   string       name_q[$];
   int          checks = 0;
   int          passes = 0;
   logic [15:0] model_ir = 16'h0000;

   instruction_controller dut (
      .clk(clk), .rst_n(rst_n), .in(in_word), .load(load), .s(s), .w(w),
      .sximm8(sximm8), .sximm5(sximm5), .shift(shift), .ALUop(ALUop),
      .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write), .vsel(vsel)
   );

   always #5 clk = ~clk;

   function automatic obs_t base(input logic [15:0] i);
      obs_t o;
      o = '0;
      o.sximm8 = {{8{i[7]}}, i[7:0]};
      o.sximm5 = {{11{i[4]}}, i[4:0]};
      o.alu_op = i[12:11];
      return o;
   endfunction

   function automatic obs_t idle_rec(input logic [15:0] i);
      obs_t o;
      o   = base(i);
      o.w = 1'b1;
      return o;
   endfunction

   function automatic obs_t reset_rec();
      obs_t o;
      o   = '0;
      o.w = 1'b1;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("w=%b la=%b lb=%b lc=%b ls=%b as=%b bs=%b wr=%b vsel=%b sh=%b rn=%0d wn=%0d op=%b imm8=%h imm5=%h",
                       o.w, o.loada, o.loadb, o.loadc, o.loads, o.asel, o.bsel, o.write,
                       o.vsel, o.shift, o.readnum, o.writenum, o.alu_op, o.sximm8, o.sximm5);
   endfunction

   // Instruction-level model: the list of per-cycle outputs following the s edge.
   task automatic buildSequence(input logic [15:0] i);
      obs_t       o;
      logic [4:0] cls;
      bit         mov_imm, mov_reg, is_cmp, needs_a, reg_op;
      cls     = i[15:11];
      mov_imm = (cls == 5'b11010);
      mov_reg = (cls == 5'b11000);
      is_cmp  = (cls == 5'b10101);
      needs_a = (cls == 5'b10100) || is_cmp || (cls == 5'b10110);
      reg_op  = mov_reg || needs_a || (cls == 5'b10111);
      seq_q.delete();
      name_q.delete();
      seq_q.push_back(base(i)); name_q.push_back("DECODE");
      if (mov_imm) begin
         o = base(i); o.readnum = i[10:8]; o.writenum = i[10:8]; o.vsel = 4'b0010; o.write = 1'b1;
         seq_q.push_back(o); name_q.push_back("WR_IMM");
      end else if (reg_op) begin
         if (needs_a) begin
            o = base(i); o.readnum = i[10:8]; o.writenum = i[10:8]; o.loada = 1'b1;
            seq_q.push_back(o); name_q.push_back("GET_A");
         end
         o = base(i); o.readnum = i[2:0]; o.writenum = i[2:0]; o.loadb = 1'b1; o.shift = i[4:3];
         seq_q.push_back(o); name_q.push_back("GET_B");
         o = base(i); o.shift = i[4:3]; o.asel = mov_reg; o.loads = is_cmp; o.loadc = !is_cmp;
         seq_q.push_back(o); name_q.push_back("EXEC");
         if (!is_cmp) begin
            o = base(i); o.readnum = i[7:5]; o.writenum = i[7:5]; o.vsel = 4'b1000;
            o.write = 1'b1; o.shift = i[4:3];
            seq_q.push_back(o); name_q.push_back("WR_REG");
         end
      end
   endtask

   task automatic cycle(input obs_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] i, input bit combined);
      if (!combined) begin
         in_word = i; load = 1'b1; s = 1'b0;
         cycle(idle_rec(model_ir), $sformatf("WAIT_LOAD@%h", i));
         model_ir = i;
         load = 1'b0;
         in_word = 16'($urandom);
      end else begin
         in_word = i; load = 1'b1;
      end
      s = 1'b1;
      cycle(idle_rec(model_ir), $sformatf("WAIT_S@%h", i));
      model_ir = i;
      buildSequence(i);
      for (int k = 0; k < seq_q.size(); k++) begin
         load    = 1'($urandom_range(0, 1));
         s       = 1'($urandom_range(0, 1));
         in_word = 16'($urandom);
         cycle(seq_q[k], $sformatf("%s@%h", name_q[k], i));
      end
      load = 1'b0;
      s    = 1'b0;
   endtask

   task automatic checkOutput();
      obs_t  e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '0;
      a.w = w; a.loada = loada; a.loadb = loadb; a.loadc = loadc; a.loads = loads;
      a.asel = asel; a.bsel = bsel; a.write = write; a.vsel = vsel; a.shift = shift;
      a.readnum = readnum; a.writenum = writenum; a.alu_op = ALUop;
      a.sximm8 = sximm8; a.sximm5 = sximm5;
      checks++;
      if (a === e) passes++;
      else $display("[TB] FAIL %s got {%s} expected {%s}", t, fmt(a), fmt(e));
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput();
   end

   function automatic logic [15:0] rand_instr();
      logic [4:0] cls;
      case ($urandom_range(0, 6))
         0:       cls = 5'b11010;
         1:       cls = 5'b11000;
         2:       cls = 5'b10100;
         3:       cls = 5'b10101;
         4:       cls = 5'b10110;
         5:       cls = 5'b10111;
         default: cls = 5'($urandom);
      endcase
      return {cls, 11'($urandom)};
   endfunction

   initial begin
      @(posedge clk);
      #1;
      s = 1'b1; load = 1'b1; in_word = 16'hFFFF;
      cycle(reset_rec(), "RST0");
      s = 1'b0; load = 1'b0;
      cycle(reset_rec(), "RST1");
      s = 1'b1;
      cycle(reset_rec(), "RST2");
      rst_n = 1'b1; s = 1'b0;
      model_ir = 16'h0000;
      cycle(idle_rec(model_ir), "WAIT_AFTER_RST");

      applyStimulus(16'hD0FB, 1'b0);
      applyStimulus(16'hA148, 1'b1);
      applyStimulus(16'hA900, 1'b0);
      applyStimulus(16'hB867, 1'b1);
      applyStimulus(16'hC095, 1'b0);
      applyStimulus(16'hE000, 1'b1);

      // Reset asserted during GET_B of an ADD aborts it before any write-back.
      in_word = 16'hA148; load = 1'b1; s = 1'b1;
      cycle(idle_rec(model_ir), "ABORT_WAIT_S");
      model_ir = 16'hA148;
      load = 1'b0; s = 1'b0;
      buildSequence(16'hA148);
      cycle(seq_q[0], "ABORT_DECODE");
      cycle(seq_q[1], "ABORT_GET_A");
      rst_n = 1'b0;
      cycle(reset_rec(), "ABORT_RST_GET_B");
      rst_n = 1'b1;
      model_ir = 16'h0000;
      cycle(idle_rec(model_ir), "ABORT_WAIT");
      cycle(idle_rec(model_ir), "ABORT_WAIT2");

      repeat (80) begin
         repeat ($urandom_range(0, 2)) begin
            in_word = 16'($urandom);
            cycle(idle_rec(model_ir), "IDLE");
         end
         applyStimulus(rand_instr(), 1'($urandom_range(0, 1)));
      end

      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
